ctrl_pipe: RTL and testbench

Main-control decoder and control-pipeline register chain for the 5-stage MIPS pipeline. It decodes the instruction held in the IF/ID register into the full control word, including the `alu_op` and `funct` pair consumed by the ALU control in EX. It then carries each control group through the ID/EX, EX/MEM and MEM/WB boundaries and inserts bubbles on stall and flush. It is the producer side of the ALUOp/funct interface.

---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/main_decoder.sv | 55 +++++
 rtl/ctrl_pipe.sv | 115 +++++++++++
 tb/tb_ctrl_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode, ALUOp constants and per-stage control group types
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       reg_dst;
   } ex_ctrl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic branch;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

endpackage

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - combinational main-control decode of opcode/funct into the control word
module main_decoder
   import ctrl_pkg::*;
#(
   parameter int FUNCT_W = 6
) (
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct_in,
   output ex_ctrl_t           ex,
   output mem_ctrl_t          mem,
   output wb_ctrl_t           wb,
   output logic [FUNCT_W-1:0] funct,
   output logic               illegal
);

   always_comb begin
      ex      = '0;
      mem     = '0;
      wb      = '0;
      funct   = '0;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ex.alu_op    = ALUOP_RTYPE;
            ex.reg_dst   = 1'b1;
            wb.reg_write = 1'b1;
            funct        = FUNCT_W'(funct_in);
         end
         OP_LW: begin
            ex.alu_op     = ALUOP_ADD;
            ex.alu_src    = 1'b1;
            mem.mem_read  = 1'b1;
            wb.reg_write  = 1'b1;
            wb.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            ex.alu_op     = ALUOP_ADD;
            ex.alu_src    = 1'b1;
            mem.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ex.alu_op  = ALUOP_SUB;
            mem.branch = 1'b1;
         end
         OP_ADDI: begin
            ex.alu_op    = ALUOP_ADD;
            ex.alu_src   = 1'b1;
            wb.reg_write = 1'b1;
         end
         // unsupported opcodes travel as a NOP tagged illegal
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control decode plus ID/EX, EX/MEM, MEM/WB control registers; CTRL_PERF_CNT_EN adds bubble_cnt
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int FUNCT_W = 6,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [31:0]        id_instr,
   input  logic               stall,
   input  logic               flush,
   output logic [1:0]         ex_alu_op,
   output logic [FUNCT_W-1:0] ex_funct,
   output logic               ex_alu_src,
   output logic               ex_reg_dst,
   output logic               ex_illegal,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_branch,
   output logic               wb_reg_write,
   output logic               wb_mem_to_reg
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   bubble_cnt
`endif
);

   ex_ctrl_t           dec_ex;
   mem_ctrl_t          dec_mem;
   wb_ctrl_t           dec_wb;
   logic [FUNCT_W-1:0] dec_funct;
   logic               dec_illegal;

   ex_ctrl_t           idex_ex;
   logic [FUNCT_W-1:0] idex_funct;
   logic               idex_illegal;
   mem_ctrl_t          idex_mem;
   wb_ctrl_t           idex_wb;
   mem_ctrl_t          exmem_mem;
   wb_ctrl_t           exmem_wb;
   wb_ctrl_t           memwb_wb;

   logic bubble;

   assign bubble = stall | flush;

   main_decoder #(.FUNCT_W(FUNCT_W)) u_dec (
      .opcode   (id_instr[31:26]),
      .funct_in (id_instr[5:0]),
      .ex       (dec_ex),
      .mem      (dec_mem),
      .wb       (dec_wb),
      .funct    (dec_funct),
      .illegal  (dec_illegal)
   );

   // stall and flush share one bubble; flush also squashes the older instruction in EX/MEM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idex_ex      <= '0;
         idex_funct   <= '0;
         idex_illegal <= 1'b0;
         idex_mem     <= '0;
         idex_wb      <= '0;
         exmem_mem    <= '0;
         exmem_wb     <= '0;
         memwb_wb     <= '0;
      end else begin
         if (bubble) begin
            idex_ex      <= '0;
            idex_funct   <= '0;
            idex_illegal <= 1'b0;
            idex_mem     <= '0;
            idex_wb      <= '0;
         end else begin
            idex_ex      <= dec_ex;
            idex_funct   <= dec_funct;
            idex_illegal <= dec_illegal;
            idex_mem     <= dec_mem;
            idex_wb      <= dec_wb;
         end
         if (flush) begin
            exmem_mem <= '0;
            exmem_wb  <= '0;
         end else begin
            exmem_mem <= idex_mem;
            exmem_wb  <= idex_wb;
         end
         memwb_wb <= exmem_wb;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bubble_cnt <= '0;
      end else if (bubble) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end
`endif

   assign ex_alu_op     = idex_ex.alu_op;
   assign ex_funct      = idex_funct;
   assign ex_alu_src    = idex_ex.alu_src;
   assign ex_reg_dst    = idex_ex.reg_dst;
   assign ex_illegal    = idex_illegal;
   assign mem_read      = exmem_mem.mem_read;
   assign mem_write     = exmem_mem.mem_write;
   assign mem_branch    = exmem_mem.branch;
   assign wb_reg_write  = memwb_wb.reg_write;
   assign wb_mem_to_reg = memwb_wb.mem_to_reg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - table-driven and directed checks of ctrl_pipe decode, pipelining, bubbles and reset
module tb_ctrl_pipe;

   typedef struct {
      logic [31:0] instr;
      logic [1:0]  alu_op;
      logic [5:0]  funct;
      logic        alu_src;
      logic        reg_dst;
      logic        illegal;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        reg_write;
      logic        mem_to_reg;
   } vec_t;

   logic        clk;
   logic        rstn;
   logic [31:0] id_instr;
   logic        stall;
   logic        flush;
   logic [1:0]  ex_alu_op;
   logic [5:0]  ex_funct;
   logic        ex_alu_src;
   logic        ex_reg_dst;
   logic        ex_illegal;
   logic        mem_read;
   logic        mem_write;
   logic        mem_branch;
   logic        wb_reg_write;
   logic        wb_mem_to_reg;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   vec_t vecs[8];
   vec_t zv;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] bubble_cnt;
   logic [1:0]  s_bubble_cnt;
   logic [1:0]  s_alu_op;
   logic [5:0]  s_funct;
   logic        s_alu_src, s_reg_dst, s_illegal, s_mem_read, s_mem_write;
   logic        s_branch, s_reg_write, s_mem_to_reg;

   ctrl_pipe #(.FUNCT_W(6), .CNT_W(2)) u_small (
      .clk(clk), .rstn(rstn), .id_instr(id_instr), .stall(stall), .flush(flush),
      .ex_alu_op(s_alu_op), .ex_funct(s_funct), .ex_alu_src(s_alu_src),
      .ex_reg_dst(s_reg_dst), .ex_illegal(s_illegal), .mem_read(s_mem_read),
      .mem_write(s_mem_write), .mem_branch(s_branch), .wb_reg_write(s_reg_write),
      .wb_mem_to_reg(s_mem_to_reg), .bubble_cnt(s_bubble_cnt)
   );
`endif

   ctrl_pipe #(.FUNCT_W(6), .CNT_W(32)) dut (
      .clk(clk), .rstn(rstn), .id_instr(id_instr), .stall(stall), .flush(flush),
      .ex_alu_op(ex_alu_op), .ex_funct(ex_funct), .ex_alu_src(ex_alu_src),
      .ex_reg_dst(ex_reg_dst), .ex_illegal(ex_illegal), .mem_read(mem_read),
      .mem_write(mem_write), .mem_branch(mem_branch), .wb_reg_write(wb_reg_write),
      .wb_mem_to_reg(wb_mem_to_reg)
`ifdef CTRL_PERF_CNT_EN
      , .bubble_cnt(bubble_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_ex(input string tag, input vec_t v);
      chk({tag, " ex_alu_op"},  32'(ex_alu_op),  32'(v.alu_op));
      chk({tag, " ex_funct"},   32'(ex_funct),   32'(v.funct));
      chk({tag, " ex_alu_src"}, 32'(ex_alu_src), 32'(v.alu_src));
      chk({tag, " ex_reg_dst"}, 32'(ex_reg_dst), 32'(v.reg_dst));
      chk({tag, " ex_illegal"}, 32'(ex_illegal), 32'(v.illegal));
   endtask

   task automatic chk_mem(input string tag, input vec_t v);
      chk({tag, " mem_read"},   32'(mem_read),   32'(v.mem_read));
      chk({tag, " mem_write"},  32'(mem_write),  32'(v.mem_write));
      chk({tag, " mem_branch"}, 32'(mem_branch), 32'(v.branch));
   endtask

   task automatic chk_wb(input string tag, input vec_t v);
      chk({tag, " wb_reg_write"},  32'(wb_reg_write),  32'(v.reg_write));
      chk({tag, " wb_mem_to_reg"}, 32'(wb_mem_to_reg), 32'(v.mem_to_reg));
   endtask

   task automatic chk_all_zero(input string tag);
      chk_ex(tag, zv);
      chk_mem(tag, zv);
      chk_wb(tag, zv);
   endtask

   task automatic chk_cnt(input string tag);
`ifdef CTRL_PERF_CNT_EN
      chk({tag, " bubble_cnt"}, bubble_cnt, 32'(exp_cnt));
`else
      checks = checks + 0;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //        instr          aluop funct  src dst ill mr mw br rw m2r
      vecs[0] = '{32'h012A4020, 2'b10, 6'h20, 0, 1, 0, 0, 0, 0, 1, 0}; // add
      vecs[1] = '{32'h8D090004, 2'b00, 6'h00, 1, 0, 0, 1, 0, 0, 1, 1}; // lw
      vecs[2] = '{32'hAD090004, 2'b00, 6'h00, 1, 0, 0, 0, 1, 0, 0, 0}; // sw
      vecs[3] = '{32'h11090004, 2'b01, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0}; // beq
      vecs[4] = '{32'h21090004, 2'b00, 6'h00, 1, 0, 0, 0, 0, 0, 1, 0}; // addi
      vecs[5] = '{32'hFC000025, 2'b00, 6'h00, 0, 0, 1, 0, 0, 0, 0, 0}; // opcode 0x3F
      vecs[6] = '{32'h08000010, 2'b00, 6'h00, 0, 0, 1, 0, 0, 0, 0, 0}; // j (unsupported)
      vecs[7] = '{32'h012A4022, 2'b10, 6'h22, 0, 1, 0, 0, 0, 0, 1, 0}; // sub
      zv      = '{32'h0, 2'b00, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0};

      rstn = 1'b0;
      id_instr = vecs[0].instr;
      stall = 1'b0;
      flush = 1'b0;
      repeat (2) step();
      chk_all_zero("reset");
      chk_cnt("reset");

      // back-to-back stream: each record appears in EX, then MEM, then WB
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         id_instr = vecs[i].instr;
         step();
         chk_ex($sformatf("vec%0d", i), vecs[i]);
         if (i >= 1) chk_mem($sformatf("vec%0d", i - 1), vecs[i - 1]);
         if (i >= 2) chk_wb($sformatf("vec%0d", i - 2), vecs[i - 2]);
      end

      // asynchronous reset between edges while sub/addi-class controls are live
      #2;
      rstn = 1'b0;
      #1;
      chk_all_zero("async_reset");
      step();
      rstn = 1'b1;
      exp_cnt = 0;

      // lw with a one-cycle load-use stall
      id_instr = vecs[1].instr;
      stall = 1'b1;
      step();
      exp_cnt++;
      chk_ex("stall_bubble", zv);
      stall = 1'b0;
      step();
      chk_ex("lw_after_stall", vecs[1]);
      id_instr = vecs[0].instr;
      step();
      chk_mem("lw_mem", vecs[1]);
      chk_cnt("after_stall");

      // beq then add; flush when beq is in MEM squashes add in EX
      id_instr = vecs[3].instr;
      step();
      chk_ex("beq_ex", vecs[3]);
      id_instr = vecs[0].instr;
      step();
      chk_mem("beq_mem", vecs[3]);
      chk_ex("add_ex", vecs[0]);
      flush = 1'b1;
      id_instr = vecs[7].instr;
      step();
      exp_cnt++;
      chk_ex("flush_idex", zv);
      chk_mem("flush_exmem", zv);
      flush = 1'b0;
      id_instr = vecs[4].instr;
      step();
      chk_wb("squashed_add_wb", zv);
      chk_mem("flush_bubble_mem", zv);
      chk_ex("addi_after_flush", vecs[4]);
      chk_cnt("after_flush");

      // stall and flush together count once per edge
      id_instr = vecs[0].instr;
      stall = 1'b1;
      flush = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         exp_cnt++;
         chk_ex($sformatf("dual_bubble%0d", k), zv);
         chk_mem($sformatf("dual_bubble%0d", k), zv);
      end
      stall = 1'b0;
      flush = 1'b0;
      chk_cnt("after_dual");
      step();
      chk_ex("add_after_dual", vecs[0]);

`ifdef CTRL_PERF_CNT_EN
      // five bubbles from reset: 32-bit counter reads 5, 2-bit counter wraps to 1
      rstn = 1'b0;
      #1;
      chk("cnt_reset", bubble_cnt, 32'd0);
      step();
      rstn = 1'b1;
      stall = 1'b1;
      repeat (5) step();
      stall = 1'b0;
      chk("cnt_five", bubble_cnt, 32'd5);
      chk("cnt_wrap_w2", 32'(s_bubble_cnt), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
